pe_mac_pipe: RTL and testbench
==============================

PE_MAC_PIPE -- requirements
Module: pe_mac_pipe

Interface
REQ-001 Parameter A_W, default 8: signed width of operand a.
REQ-002 Parameter B_W, default 19: signed width of operand b and preload d.
REQ-003 Parameter C_W, default 19: signed width of io_out_c.
REQ-004 Parameter ACC_W, default 32: signed accumulator width.
REQ-005 Parameter SHIFT_W, default 5: width of the shift control.
REQ-006 Parameter IN_STAGES, default 1, range 0..3: number of input register stages.
REQ-007 Parameter OUT_STAGES, default 1, range 1..3: number of output register stages.
REQ-008 Port CLK, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-009 Port RST, input, 1: synchronous, active-high reset.
REQ-010 Ports io_in_a (A_W), io_in_b (B_W), io_in_d (B_W), inputs: operands and preload value.
REQ-011 Ports io_in_valid (1), io_in_control_shift (SHIFT_W), io_in_control_propagate (1), inputs: control.
REQ-012 Ports io_out_a (A_W), io_out_b (B_W), io_out_c (C_W), outputs: forwarded a, forwarded b, and result.
REQ-013 Ports io_out_valid (1), io_out_control_shift (SHIFT_W), io_out_control_propagate (1), outputs: forwarded control.

Function
REQ-014 The block SHALL hold two accumulators, acc0 and acc1, each ACC_W signed.
REQ-015 A valid core cycle with prop=1 SHALL drive c = rs(acc0), load acc0 with sign-extended d, and set acc1 to acc1 + a*b.
REQ-016 A valid core cycle with prop=0 SHALL drive c = rs(acc1), load acc1 with sign-extended d, and set acc0 to acc0 + a*b.
REQ-017 The product a*b SHALL be a signed full product, sign-extended or truncated to ACC_W; accumulation SHALL wrap modulo 2^ACC_W.
REQ-018 rs(x) SHALL be computed as follows: add 2^(shift-1) when shift>0, then arithmetic right shift by shift, then saturate to the signed C_W range.
REQ-019 An invalid core cycle SHALL leave both accumulators unchanged and SHALL hold the previous core c value.
REQ-020 a, b, shift, propagate and valid SHALL pass through unchanged every cycle, valid or not.
REQ-021 Latency from input to output SHALL be exactly IN_STAGES+OUT_STAGES cycles for all outputs; c SHALL reflect the accumulator state before that cycle's update.
REQ-022 A change of propagate SHALL need no bubble: back-to-back valid cycles with alternating propagate SHALL be legal.
REQ-023 The pipeline SHALL have no stall and no backpressure; every input cycle SHALL produce exactly one output cycle.

Reset
REQ-024 While RST=1 at a clock edge, all pipeline stages, both accumulators and all outputs SHALL become 0 at that edge.
REQ-025 Reset mid-operation SHALL discard in-flight data; io_out_valid SHALL stay 0 until new valid inputs traverse the full latency.
REQ-026 There SHALL be no asynchronous behaviour and no reset-dependent combinational paths to outputs.

Structure
REQ-027 A shared package pe_pkg SHALL hold the default width constants and the rs round/shift/saturate function.
REQ-028 A sub-module pe_pipe_stage SHALL be used: a parametrised-width, parametrised-depth register delay with synchronous reset, instantiated for the input and output stages.
REQ-029 The core (accumulators plus MAC) SHALL be in pe_mac_pipe itself, with no further hierarchy.

Verification
REQ-030 Bench SHALL cover: after reset, defaults; three valid cycles with prop=0, a=3, b=4, d=0, then prop=1, shift=0 -> io_out_c=36 with io_out_valid=1 exactly 2 cycles after the fourth input.
REQ-031 Bench SHALL cover rounding: acc0=37, shift=2 -> 9; acc0=-37, shift=2 -> -9.
REQ-032 Bench SHALL cover saturation: prop=0, a=100, b=3000, then prop=1, shift=0 -> io_out_c=262143; mirrored a=-100 -> -262144.
REQ-033 Bench SHALL cover a bubble: valid=0 between accumulation cycles -> accumulators unchanged, io_out_valid=0 for that slot, io_out_c held, a/b still forwarded.
REQ-034 Bench SHALL cover reset mid-operation: RST=1 for one cycle during accumulation -> next cycle all outputs 0, and a subsequent readout returns only post-reset sums.
REQ-035 Bench SHALL cover parameter sweep: IN_STAGES=0/OUT_STAGES=2 and IN_STAGES=3/OUT_STAGES=3 -> identical result sequences, delayed by 2 and 6 cycles respectively.

Source files
------------

// File: rtl/pe_pkg.sv
// ---------------------------------------------------------------------------
// pe_pkg
// Shared definitions for the processing-element MAC pipeline.
//   - Default operand / result / accumulator / shift widths.
//   - rs(): round-half-up, arithmetic right shift, saturate to a signed
//     result width. Works on a 64-bit signed view of the accumulator so the
//     rounding addend can never overflow; callers truncate the saturated
//     result down to their own result width.
// ---------------------------------------------------------------------------
package pe_pkg;

    localparam int PE_A_W     = 8;
    localparam int PE_B_W     = 19;
    localparam int PE_C_W     = 19;
    localparam int PE_ACC_W   = 32;
    localparam int PE_SHIFT_W = 5;

    function automatic logic signed [63:0] rs(
        input logic signed [63:0] x,
        input int unsigned        shift,
        input int unsigned        c_w
    );
        logic signed [63:0] v;
        logic signed [63:0] v_max;
        logic signed [63:0] v_min;
        v = x;
        if (shift > 0) begin
            v = v + (64'sd1 <<< (shift - 1));
        end
        v     = v >>> shift;
        v_max = (64'sd1 <<< (c_w - 1)) - 64'sd1;
        v_min = -(64'sd1 <<< (c_w - 1));
        if (v > v_max) begin
            v = v_max;
        end else if (v < v_min) begin
            v = v_min;
        end
        return v;
    endfunction

endpackage

// File: rtl/pe_mac_pipe_if.sv
// ---------------------------------------------------------------------------
// pe_mac_pipe_if
// Bundles the operand, control and result signals of pe_mac_pipe.
//   io_in_*  : a, b, preload d, valid, shift, propagate (driven by master)
//   io_out_* : forwarded a, b, shift, propagate, valid and result c
//              (driven by the PE, the slave side)
// ---------------------------------------------------------------------------
interface pe_mac_pipe_if
    import pe_pkg::*;
#(
    parameter int A_W     = PE_A_W,
    parameter int B_W     = PE_B_W,
    parameter int C_W     = PE_C_W,
    parameter int SHIFT_W = PE_SHIFT_W
) ();

    logic [A_W-1:0]     io_in_a;
    logic [B_W-1:0]     io_in_b;
    logic [B_W-1:0]     io_in_d;
    logic               io_in_valid;
    logic [SHIFT_W-1:0] io_in_control_shift;
    logic               io_in_control_propagate;

    logic [A_W-1:0]     io_out_a;
    logic [B_W-1:0]     io_out_b;
    logic [C_W-1:0]     io_out_c;
    logic               io_out_valid;
    logic [SHIFT_W-1:0] io_out_control_shift;
    logic               io_out_control_propagate;

    modport master (
        output io_in_a, io_in_b, io_in_d, io_in_valid,
               io_in_control_shift, io_in_control_propagate,
        input  io_out_a, io_out_b, io_out_c, io_out_valid,
               io_out_control_shift, io_out_control_propagate
    );

    modport slave (
        input  io_in_a, io_in_b, io_in_d, io_in_valid,
               io_in_control_shift, io_in_control_propagate,
        output io_out_a, io_out_b, io_out_c, io_out_valid,
               io_out_control_shift, io_out_control_propagate
    );

endinterface

// File: rtl/pe_pipe_stage.sv
// ---------------------------------------------------------------------------
// pe_pipe_stage
// Register delay line of DEPTH stages over a W-bit bundle, synchronous
// active-high reset clears every stage. DEPTH=0 is a plain wire.
//   CLK, RST : clock, synchronous reset
//   i_d      : bundle in
//   o_q      : bundle delayed by DEPTH cycles
// ---------------------------------------------------------------------------
module pe_pipe_stage #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign o_q = i_d;
        end else begin : g_regs
            for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
                logic [W-1:0] r_q;
                logic [W-1:0] w_src;
                if (gi == 0) begin : g_first
                    assign w_src = i_d;
                end else begin : g_chain
                    assign w_src = g_stage[gi-1].r_q;
                end
                always_ff @(posedge CLK) begin
                    if (RST) begin
                        r_q <= '0;
                    end else begin
                        r_q <= w_src;
                    end
                end
            end
            assign o_q = g_stage[DEPTH-1].r_q;
        end
    endgenerate

endmodule

// File: rtl/pe_mac_pipe.sv
// ---------------------------------------------------------------------------
// pe_mac_pipe
// Weight-stationary style processing element with two ping-pong
// accumulators. Each valid core cycle one accumulator is read out through
// rs() and reloaded with the preload d, while the other accumulates a*b;
// propagate selects which is which. Inputs pass through IN_STAGES register
// stages before the core, and the core outputs through OUT_STAGES stages.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : pe_mac_pipe_if slave (io_in_* operands/control,
//              io_out_* forwarded operands/control and result c)
// ---------------------------------------------------------------------------
module pe_mac_pipe
    import pe_pkg::*;
#(
    parameter int A_W        = PE_A_W,
    parameter int B_W        = PE_B_W,
    parameter int C_W        = PE_C_W,
    parameter int ACC_W      = PE_ACC_W,
    parameter int SHIFT_W    = PE_SHIFT_W,
    parameter int IN_STAGES  = 1,
    parameter int OUT_STAGES = 1
) (
    input  logic         CLK,
    input  logic         RST,
    pe_mac_pipe_if.slave bus
);

    localparam int IN_W  = A_W + 2 * B_W + SHIFT_W + 2;
    localparam int OUT_W = A_W + B_W + C_W + SHIFT_W + 2;

    // ---------------- input stages ----------------
    logic [IN_W-1:0] w_in_bundle;
    logic [IN_W-1:0] w_core_bundle;

    assign w_in_bundle = {bus.io_in_a, bus.io_in_b, bus.io_in_d,
                          bus.io_in_control_shift, bus.io_in_control_propagate,
                          bus.io_in_valid};

    pe_pipe_stage #(.W(IN_W), .DEPTH(IN_STAGES)) u_in_stage (
        .CLK (CLK),
        .RST (RST),
        .i_d (w_in_bundle),
        .o_q (w_core_bundle)
    );

    logic signed [A_W-1:0]   w_core_a;
    logic signed [B_W-1:0]   w_core_b;
    logic signed [B_W-1:0]   w_core_d;
    logic [SHIFT_W-1:0]      w_core_shift;
    logic                    w_core_prop;
    logic                    w_core_valid;

    assign {w_core_a, w_core_b, w_core_d, w_core_shift, w_core_prop,
            w_core_valid} = w_core_bundle;

    // ---------------- core: accumulators + MAC ----------------
    logic signed [ACC_W-1:0] r_acc0;
    logic signed [ACC_W-1:0] r_acc1;
    logic signed [C_W-1:0]   r_c_hold;

    logic signed [ACC_W-1:0] w_prod;
    logic signed [ACC_W-1:0] w_d_ext;
    logic signed [ACC_W-1:0] w_sel_acc;
    logic signed [C_W-1:0]   w_rs;
    logic signed [C_W-1:0]   w_core_c;

    // Operands are sign-extended (or truncated) to ACC_W before the
    // multiply, so the product lands modulo 2^ACC_W as the accumulator wraps.
    assign w_prod    = ACC_W'(w_core_a) * ACC_W'(w_core_b);
    assign w_d_ext   = ACC_W'(w_core_d);
    // Readout uses the accumulator value from before this cycle's update.
    assign w_sel_acc = w_core_prop ? r_acc0 : r_acc1;
    assign w_rs      = C_W'(rs(64'(w_sel_acc), 32'(w_core_shift), C_W));
    // A bubble repeats the last produced result instead of a fresh readout.
    assign w_core_c  = w_core_valid ? w_rs : r_c_hold;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_acc0   <= '0;
            r_acc1   <= '0;
            r_c_hold <= '0;
        end else if (w_core_valid) begin
            r_c_hold <= w_rs;
            if (w_core_prop) begin
                r_acc0 <= w_d_ext;
                r_acc1 <= r_acc1 + w_prod;
            end else begin
                r_acc1 <= w_d_ext;
                r_acc0 <= r_acc0 + w_prod;
            end
        end
    end

    // ---------------- output stages ----------------
    logic [OUT_W-1:0] w_core_out;
    logic [OUT_W-1:0] w_out_bundle;

    assign w_core_out = {w_core_a, w_core_b, w_core_c, w_core_shift,
                         w_core_prop, w_core_valid};

    pe_pipe_stage #(.W(OUT_W), .DEPTH(OUT_STAGES)) u_out_stage (
        .CLK (CLK),
        .RST (RST),
        .i_d (w_core_out),
        .o_q (w_out_bundle)
    );

    assign {bus.io_out_a, bus.io_out_b, bus.io_out_c, bus.io_out_control_shift,
            bus.io_out_control_propagate, bus.io_out_valid} = w_out_bundle;

endmodule

// File: tb/tb_pe_mac_pipe.sv
// ---------------------------------------------------------------------------
// tb_pe_mac_pipe
// Three PE instances (IN/OUT stages 1/1, 0/2, 3/3) share one stimulus
// stream. A reference model computes the expected output for every input
// cycle and pushes it into one queue per instance; each queue is popped and
// compared when that instance's output for the cycle is due.
// ---------------------------------------------------------------------------
module tb_pe_mac_pipe;
    import pe_pkg::*;

    localparam int A_W     = PE_A_W;
    localparam int B_W     = PE_B_W;
    localparam int C_W     = PE_C_W;
    localparam int SHIFT_W = PE_SHIFT_W;
    localparam int LAT0    = 2;
    localparam int LAT1    = 2;
    localparam int LAT2    = 6;

    typedef struct {
        int c;
        int v;
        int a;
        int b;
        int sh;
        int p;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    pe_mac_pipe_if #(.A_W(A_W), .B_W(B_W), .C_W(C_W), .SHIFT_W(SHIFT_W)) io0 ();
    pe_mac_pipe_if #(.A_W(A_W), .B_W(B_W), .C_W(C_W), .SHIFT_W(SHIFT_W)) io1 ();
    pe_mac_pipe_if #(.A_W(A_W), .B_W(B_W), .C_W(C_W), .SHIFT_W(SHIFT_W)) io2 ();

    pe_mac_pipe #(.IN_STAGES(1), .OUT_STAGES(1)) u_dut0 (.CLK(CLK), .RST(RST), .bus(io0));
    pe_mac_pipe #(.IN_STAGES(0), .OUT_STAGES(2)) u_dut1 (.CLK(CLK), .RST(RST), .bus(io1));
    pe_mac_pipe #(.IN_STAGES(3), .OUT_STAGES(3)) u_dut2 (.CLK(CLK), .RST(RST), .bus(io2));

    int n_tests = 0;
    int n_fail  = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int m_acc0 = 0;
    int m_acc1 = 0;
    int m_hold = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int tb_rs(input int x, input int sh);
        longint v;
        longint lim;
        v = longint'(x);
        if (sh > 0) v = v + (longint'(1) << (sh - 1));
        v = v >>> sh;
        lim = longint'(1) << (C_W - 1);
        if (v > lim - 1) v = lim - 1;
        else if (v < -lim) v = -lim;
        return int'(v);
    endfunction

    function automatic exp_t zero_exp();
        exp_t e;
        e.c = 0; e.v = 0; e.a = 0; e.b = 0; e.sh = 0; e.p = 0;
        return e;
    endfunction

    task automatic sb_push(input exp_t e, input bit rst);
        if (rst) begin
            q0.delete(); q1.delete(); q2.delete();
            for (int i = 0; i < LAT0 - 1; i++) q0.push_back(zero_exp());
            for (int i = 0; i < LAT1 - 1; i++) q1.push_back(zero_exp());
            for (int i = 0; i < LAT2 - 1; i++) q2.push_back(zero_exp());
        end
        q0.push_back(e);
        q1.push_back(e);
        q2.push_back(e);
    endtask

    task automatic cmp_out(input string tag, input exp_t e,
                           input logic [C_W-1:0] c, input logic v,
                           input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                           input logic [SHIFT_W-1:0] sh, input logic p);
        check({tag, ".c"},     longint'($signed(c)), longint'(e.c));
        check({tag, ".valid"}, longint'(v),          longint'(e.v));
        check({tag, ".a"},     longint'($signed(a)), longint'(e.a));
        check({tag, ".b"},     longint'($signed(b)), longint'(e.b));
        check({tag, ".shift"}, longint'(sh),         longint'(e.sh));
        check({tag, ".prop"},  longint'(p),          longint'(e.p));
    endtask

    task automatic drive_all(input bit v, input bit p, input int a, input int b,
                             input int d, input int sh);
        io0.io_in_a = A_W'(a); io0.io_in_b = B_W'(b); io0.io_in_d = B_W'(d);
        io0.io_in_valid = v; io0.io_in_control_propagate = p;
        io0.io_in_control_shift = SHIFT_W'(sh);
        io1.io_in_a = A_W'(a); io1.io_in_b = B_W'(b); io1.io_in_d = B_W'(d);
        io1.io_in_valid = v; io1.io_in_control_propagate = p;
        io1.io_in_control_shift = SHIFT_W'(sh);
        io2.io_in_a = A_W'(a); io2.io_in_b = B_W'(b); io2.io_in_d = B_W'(d);
        io2.io_in_valid = v; io2.io_in_control_propagate = p;
        io2.io_in_control_shift = SHIFT_W'(sh);
    endtask

    // One clock cycle: drive inputs, update the model, push expectations,
    // then compare the output each instance produces on this edge.
    task automatic step(input bit rst, input bit v, input bit p, input int a,
                        input int b, input int d, input int sh);
        exp_t e;
        exp_t o;
        @(negedge CLK);
        RST = rst;
        drive_all(v, p, a, b, d, sh);
        if (rst) begin
            e = zero_exp();
            m_acc0 = 0; m_acc1 = 0; m_hold = 0;
        end else begin
            e.a = a; e.b = b; e.sh = sh; e.p = int'(p); e.v = int'(v);
            if (v) begin
                if (p) begin
                    e.c = tb_rs(m_acc0, sh);
                    m_acc0 = d;
                    m_acc1 = m_acc1 + a * b;
                end else begin
                    e.c = tb_rs(m_acc1, sh);
                    m_acc1 = d;
                    m_acc0 = m_acc0 + a * b;
                end
                m_hold = e.c;
            end else begin
                e.c = m_hold;
            end
        end
        sb_push(e, rst);
        @(posedge CLK);
        #1;
        o = q0.pop_front();
        cmp_out("i1o1", o, io0.io_out_c, io0.io_out_valid, io0.io_out_a, io0.io_out_b,
                io0.io_out_control_shift, io0.io_out_control_propagate);
        o = q1.pop_front();
        cmp_out("i0o2", o, io1.io_out_c, io1.io_out_valid, io1.io_out_a, io1.io_out_b,
                io1.io_out_control_shift, io1.io_out_control_propagate);
        o = q2.pop_front();
        cmp_out("i3o3", o, io2.io_out_c, io2.io_out_valid, io2.io_out_a, io2.io_out_b,
                io2.io_out_control_shift, io2.io_out_control_propagate);
    endtask

    task automatic bubble();
        step(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
    endtask

    initial begin
        drive_all(1'b0, 1'b0, 0, 0, 0, 0);

        // Reset and defaults
        step(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        step(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        check("reset_c",     longint'($signed(io0.io_out_c)), 0);
        check("reset_valid", longint'(io0.io_out_valid), 0);
        check("reset_a",     longint'($signed(io2.io_out_a)), 0);

        // Three MACs into acc0, then readout with shift 0
        step(1'b0, 1'b1, 1'b0, 3, 4, 0, 0);
        step(1'b0, 1'b1, 1'b0, 3, 4, 0, 0);
        step(1'b0, 1'b1, 1'b0, 3, 4, 0, 0);
        step(1'b0, 1'b1, 1'b1, 0, 0, 0, 0);
        check("mac_pre_c", longint'($signed(io0.io_out_c)), 0);
        check("mac_pre_prop", longint'(io0.io_out_control_propagate), 0);
        bubble();
        check("mac36_c",     longint'($signed(io0.io_out_c)), 36);
        check("mac36_valid", longint'(io0.io_out_valid), 1);

        // Rounding, positive and negative
        step(1'b0, 1'b1, 1'b1, 0, 0, 37, 0);
        step(1'b0, 1'b1, 1'b1, 0, 0, 0, 2);
        bubble();
        check("round_pos", longint'($signed(io0.io_out_c)), 9);
        step(1'b0, 1'b1, 1'b1, 0, 0, -37, 0);
        step(1'b0, 1'b1, 1'b1, 0, 0, 0, 2);
        bubble();
        check("round_neg", longint'($signed(io0.io_out_c)), -9);

        // Saturation, both rails
        step(1'b0, 1'b1, 1'b0, 100, 3000, 0, 0);
        step(1'b0, 1'b1, 1'b1, 0, 0, 0, 0);
        bubble();
        check("sat_pos", longint'($signed(io0.io_out_c)), 262143);
        step(1'b0, 1'b1, 1'b0, -100, 3000, 0, 0);
        step(1'b0, 1'b1, 1'b1, 0, 0, 0, 0);
        bubble();
        check("sat_neg", longint'($signed(io0.io_out_c)), -262144);

        // Bubble between accumulation cycles
        step(1'b0, 1'b1, 1'b0, 5, 6, 11, 0);
        step(1'b0, 1'b1, 1'b0, 1, 1, 0, 0);
        step(1'b0, 1'b0, 1'b0, 7, 8, 0, 0);
        step(1'b0, 1'b1, 1'b0, 2, 2, 0, 0);
        check("bub_valid", longint'(io0.io_out_valid), 0);
        check("bub_a",     longint'($signed(io0.io_out_a)), 7);
        check("bub_b",     longint'($signed(io0.io_out_b)), 8);
        check("bub_c_hold", longint'($signed(io0.io_out_c)), 11);
        step(1'b0, 1'b1, 1'b1, 0, 0, 0, 0);
        bubble();
        check("bub_sum", longint'($signed(io0.io_out_c)), 35);

        // Reset in the middle of accumulation
        step(1'b0, 1'b1, 1'b0, 10, 10, 0, 0);
        step(1'b1, 1'b1, 1'b0, 9, 9, 0, 0);
        check("mrst_c",     longint'($signed(io0.io_out_c)), 0);
        check("mrst_valid", longint'(io0.io_out_valid), 0);
        check("mrst_a",     longint'($signed(io0.io_out_a)), 0);
        check("mrst_valid2", longint'(io2.io_out_valid), 0);
        step(1'b0, 1'b1, 1'b0, 2, 3, 0, 0);
        step(1'b0, 1'b1, 1'b1, 0, 0, 0, 0);
        bubble();
        check("mrst_sum", longint'($signed(io0.io_out_c)), 6);

        // Random traffic: alternating propagate, bubbles, occasional reset
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 255)) - 128,
                 int'($urandom_range(0, 524287)) - 262144,
                 int'($urandom_range(0, 524287)) - 262144,
                 int'($urandom_range(0, 31)));
        end
        for (int i = 0; i < LAT2; i++) bubble();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
